// File: rtl/passcode_entry_pkg.sv
// Shared alarm-system definitions: controller state encoding, system clock rate
// and a helper that says whether the alarm currently expects a code.
package passcode_entry_pkg;

  localparam int CLK_HZ = 50_000_000;

  typedef enum logic [1:0] {
    STATE_IDLE    = 2'd0,
    STATE_SET     = 2'd1,
    STATE_TRIGGER = 2'd2,
    STATE_ALERT   = 2'd3
  } fsm_state_t;

  function automatic logic is_armed(input fsm_state_t s);
    return (s == STATE_SET) || (s == STATE_TRIGGER);
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Synchronizes a raw active-low push button, debounces it and emits a one-cycle
// pulse on every debounced press (released-to-pressed transition).
module button_debounce
  import passcode_entry_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = CLK_HZ / 50
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    (DEBOUNCE_CYCLES > 1) ? CNT_W'(DEBOUNCE_CYCLES - 1) : {CNT_W{1'b0}};

  logic             sync1_r;
  logic             sync2_r;
  logic             stable_r;
  logic             press_r;
  logic [CNT_W-1:0] cnt_r;

  // A new level is accepted only after DEBOUNCE_CYCLES consecutive synchronized samples
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_r  <= 1'b1;
      sync2_r  <= 1'b1;
      stable_r <= 1'b1;
      press_r  <= 1'b0;
      cnt_r    <= {CNT_W{1'b0}};
    end else begin
      sync1_r <= btn;
      sync2_r <= sync1_r;
      press_r <= 1'b0;
      if (sync2_r == stable_r) begin
        cnt_r <= {CNT_W{1'b0}};
      end else if (cnt_r == CNT_LAST) begin
        cnt_r    <= {CNT_W{1'b0}};
        stable_r <= sync2_r;
        press_r  <= ~sync2_r;
      end else begin
        cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign press = press_r;

endmodule

// File: rtl/passcode_entry.sv
// Keypad-style passcode entry for the alarm: collects four digits, checks them
// against PASSCODE and enforces a timed lockout after too many wrong codes.
module passcode_entry
  import passcode_entry_pkg::*;
#(
  parameter logic [15:0] PASSCODE        = 16'h1234,
  parameter int          DEBOUNCE_CYCLES = CLK_HZ / 50,
  parameter int          LOCKOUT_CYCLES  = CLK_HZ * 10,
  parameter int          MAX_ATTEMPTS    = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_enter,
  input  logic [3:0] digit_sw,
  input  fsm_state_t system_state,
  output logic       passcode_correct,
  output logic       passcode_wrong,
  output logic [2:0] digits_entered,
  output logic [1:0] attempts_left,
  output logic       locked_out
);

  typedef enum logic [2:0] {
    P_DISARMED = 3'd0,
    P_ENTRY    = 3'd1,
    P_CHECK    = 3'd2,
    P_CORRECT  = 3'd3,
    P_LOCKOUT  = 3'd4
  } pstate_t;

  localparam logic [1:0]  ATT_MAX   = 2'(MAX_ATTEMPTS);
  localparam logic [31:0] LOCK_LAST = (LOCKOUT_CYCLES > 0) ? 32'(LOCKOUT_CYCLES - 1) : 32'd0;

  pstate_t     state_r;
  logic [15:0] buf_r;
  logic [31:0] lock_cnt_r;
  logic [2:0]  digits_r;
  logic [1:0]  att_r;
  logic        correct_r;
  logic        wrong_r;
  logic        locked_r;
  logic        press_s;
  logic        forced_s;
  logic [1:0]  att_dec_s;

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk  (clk),
    .rst  (rst),
    .btn  (btn_enter),
    .press(press_s)
  );

  assign forced_s = ~is_armed(system_state);

  // Remaining attempts after a wrong code, held at zero rather than wrapping
  always_comb begin
    att_dec_s = 2'd0;
    if (att_r != 2'd0) begin
      att_dec_s = att_r - 2'd1;
    end else begin
      att_dec_s = 2'd0;
    end
  end

  // Entry FSM; an idle/alert alarm overrides every in-flight press, check or expiry
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r    <= P_DISARMED;
      buf_r      <= 16'h0000;
      lock_cnt_r <= 32'd0;
      digits_r   <= 3'd0;
      att_r      <= ATT_MAX;
      correct_r  <= 1'b0;
      wrong_r    <= 1'b0;
      locked_r   <= 1'b0;
    end else begin
      wrong_r <= 1'b0;
      if (forced_s) begin
        state_r    <= P_DISARMED;
        buf_r      <= 16'h0000;
        digits_r   <= 3'd0;
        correct_r  <= 1'b0;
        locked_r   <= 1'b0;
        lock_cnt_r <= 32'd0;
        if (system_state == STATE_IDLE) begin
          att_r <= ATT_MAX;
        end
      end else begin
        case (state_r)
          P_DISARMED: state_r <= P_ENTRY;
          P_ENTRY: begin
            if (press_s) begin
              buf_r    <= {buf_r[11:0], digit_sw};
              digits_r <= digits_r + 3'd1;
              if (digits_r == 3'd3) begin
                state_r <= P_CHECK;
              end
            end
          end
          P_CHECK: begin
            if (buf_r == PASSCODE) begin
              state_r   <= P_CORRECT;
              correct_r <= 1'b1;
            end else begin
              wrong_r  <= 1'b1;
              att_r    <= att_dec_s;
              buf_r    <= 16'h0000;
              digits_r <= 3'd0;
              if (att_dec_s == 2'd0) begin
                state_r    <= P_LOCKOUT;
                locked_r   <= 1'b1;
                lock_cnt_r <= 32'd0;
              end else begin
                state_r <= P_ENTRY;
              end
            end
          end
          P_CORRECT: correct_r <= 1'b1;
          P_LOCKOUT: begin
            if (lock_cnt_r >= LOCK_LAST) begin
              state_r    <= P_ENTRY;
              att_r      <= ATT_MAX;
              locked_r   <= 1'b0;
              lock_cnt_r <= 32'd0;
            end else if (lock_cnt_r != 32'hFFFF_FFFF) begin
              lock_cnt_r <= lock_cnt_r + 32'd1;
            end
          end
          default: begin
            state_r   <= P_DISARMED;
            buf_r     <= 16'h0000;
            digits_r  <= 3'd0;
            correct_r <= 1'b0;
            locked_r  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign passcode_correct = correct_r;
  assign passcode_wrong   = wrong_r;
  assign digits_entered   = digits_r;
  assign attempts_left    = att_r;
  assign locked_out       = locked_r;

endmodule

// File: tb/tb_passcode_entry.sv
// Scoreboard bench for passcode_entry: stimulus queues the expected output
// changes, a negedge monitor pops one entry per observed change or snapshot.
module tb_passcode_entry;
  import passcode_entry_pkg::*;

  localparam int K_CHG  = 0;
  localparam int K_SNAP = 1;

  typedef struct packed {
    logic       correct;
    logic       wrong;
    logic [2:0] digits;
    logic [1:0] att;
    logic       locked;
  } snap_t;

  typedef struct {
    int    kind;
    int    abs_cyc;
    int    gap;
    snap_t s;
    string name;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       btn_enter;
  logic [3:0] digit_sw;
  fsm_state_t system_state;
  logic       passcode_correct;
  logic       passcode_wrong;
  logic [2:0] digits_entered;
  logic [1:0] attempts_left;
  logic       locked_out;

  exp_t  sb[$];
  int    cyc = 0;
  int    n_tests = 0;
  int    n_fail = 0;
  int    last_chg = 0;
  bit    mon_en = 1'b0;
  bit    done = 1'b0;
  bit    final_done = 1'b0;
  snap_t prev;

  passcode_entry #(
    .PASSCODE       (16'h1234),
    .DEBOUNCE_CYCLES(4),
    .LOCKOUT_CYCLES (20),
    .MAX_ATTEMPTS   (3)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .btn_enter       (btn_enter),
    .digit_sw        (digit_sw),
    .system_state    (system_state),
    .passcode_correct(passcode_correct),
    .passcode_wrong  (passcode_wrong),
    .digits_entered  (digits_entered),
    .attempts_left   (attempts_left),
    .locked_out      (locked_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input exp_t e, input snap_t cur, input int gap_act, input int kind_act);
    n_tests++;
    if (cur != e.s || e.kind != kind_act || (e.gap >= 0 && gap_act != e.gap) ||
        (e.abs_cyc >= 0 && cyc != e.abs_cyc)) begin
      n_fail++;
      $display("FAIL %s: got c=%0b w=%0b d=%0d a=%0d l=%0b cyc=%0d gap=%0d; want c=%0b w=%0b d=%0d a=%0d l=%0b cyc=%0d gap=%0d",
               e.name, cur.correct, cur.wrong, cur.digits, cur.att, cur.locked, cyc, gap_act,
               e.s.correct, e.s.wrong, e.s.digits, e.s.att, e.s.locked, e.abs_cyc, e.gap);
    end
  endtask

  // Monitor: scheduled snapshots first, otherwise every output change pops one entry
  always @(negedge clk) begin
    snap_t cur;
    exp_t  e;
    cur = '{passcode_correct, passcode_wrong, digits_entered, attempts_left, locked_out};
    if (mon_en) begin
      if (sb.size() > 0 && sb[0].kind == K_SNAP && sb[0].abs_cyc == cyc) begin
        e = sb.pop_front();
        check(e, cur, cyc - last_chg, K_SNAP);
        if (cur != prev) last_chg = cyc;
      end else if (cur != prev) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_change: got c=%0b w=%0b d=%0d a=%0d l=%0b at cyc=%0d, want no change",
                   cur.correct, cur.wrong, cur.digits, cur.att, cur.locked, cyc);
        end else begin
          e = sb.pop_front();
          check(e, cur, cyc - last_chg, K_CHG);
        end
        last_chg = cyc;
      end
    end
    if (done && !final_done) begin
      n_tests++;
      if (sb.size() != 0) begin
        n_fail++;
        $display("FAIL leftover_expectations: got %0d pending (first %s), want 0", sb.size(), sb[0].name);
      end
      final_done = 1'b1;
    end
    prev = cur;
  end

  task automatic push(input string nm, input int kind, input int gap, input int abs_c,
                      input logic c, input logic w, input logic [2:0] d, input logic [1:0] a,
                      input logic l);
    exp_t e;
    e.kind = kind;
    e.abs_cyc = abs_c;
    e.gap = gap;
    e.s = '{c, w, d, a, l};
    e.name = nm;
    sb.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [3:0] d);
    digit_sw = d;
    btn_enter = 1'b0;
    tick(8);
    btn_enter = 1'b1;
    tick(8);
  endtask

  // outcome 0: match, 1: mismatch, 2: mismatch that starts the lockout
  task automatic enter_code(input logic [15:0] code, input logic [1:0] att, input int outcome);
    logic [1:0] na;
    na = att - 2'd1;
    for (int i = 1; i <= 4; i++) push($sformatf("digit%0d", i), K_CHG, -1, -1, 1'b0, 1'b0, 3'(i), att, 1'b0);
    if (outcome == 0) begin
      push("correct_rise", K_CHG, 1, -1, 1'b1, 1'b0, 3'd4, att, 1'b0);
    end else begin
      push("wrong_pulse", K_CHG, 1, -1, 1'b0, 1'b1, 3'd0, na, outcome == 2);
      push("wrong_end", K_CHG, 1, -1, 1'b0, 1'b0, 3'd0, na, outcome == 2);
      if (outcome == 2) push("lockout_end", K_CHG, 19, -1, 1'b0, 1'b0, 3'd0, 2'd3, 1'b0);
    end
    for (int i = 3; i >= 0; i--) press(code[i*4 +: 4]);
  endtask

  initial begin
    rst = 1'b0;
    btn_enter = 1'b1;
    digit_sw = 4'd0;
    system_state = STATE_IDLE;
    tick(3);
    push("reset_state", K_SNAP, -1, cyc + 1, 1'b0, 1'b0, 3'd0, 2'd3, 1'b0);
    mon_en = 1'b1;
    tick(1);
    rst = 1'b1;
    tick(2);

    // Correct code, held until the alarm goes idle
    system_state = STATE_SET;
    tick(2);
    enter_code(16'h1234, 2'd3, 0);
    tick(30);
    push("idle_clears_correct", K_CHG, -1, cyc + 1, 1'b0, 1'b0, 3'd0, 2'd3, 1'b0);
    system_state = STATE_IDLE;
    tick(3);

    // Wrong codes down to lockout (hex digits included), press ignored, then recovery
    system_state = STATE_SET;
    tick(2);
    enter_code(16'h1235, 2'd3, 1);
    tick(4);
    enter_code(16'h9999, 2'd2, 1);
    tick(4);
    enter_code(16'hABCD, 2'd1, 2);
    press(4'h1);
    tick(4);
    enter_code(16'h1234, 2'd3, 0);
    tick(5);
    push("idle_after_relock", K_CHG, -1, cyc + 1, 1'b0, 1'b0, 3'd0, 2'd3, 1'b0);
    system_state = STATE_IDLE;
    tick(3);

    // Bounce, alert abort, set->trigger continuity, resets
    system_state = STATE_SET;
    tick(2);
    enter_code(16'h5555, 2'd3, 1);
    tick(4);
    push("bounce_one_digit", K_CHG, -1, -1, 1'b0, 1'b0, 3'd1, 2'd2, 1'b0);
    digit_sw = 4'h1;
    btn_enter = 1'b0; tick(1);
    btn_enter = 1'b1; tick(1);
    btn_enter = 1'b0; tick(11);
    btn_enter = 1'b1; tick(10);
    push("second_digit", K_CHG, -1, -1, 1'b0, 1'b0, 3'd2, 2'd2, 1'b0);
    press(4'h2);
    push("alert_clears_digits", K_CHG, -1, cyc + 1, 1'b0, 1'b0, 3'd0, 2'd2, 1'b0);
    system_state = STATE_ALERT;
    tick(3);
    system_state = STATE_SET;
    tick(2);
    push("set_digit1", K_CHG, -1, -1, 1'b0, 1'b0, 3'd1, 2'd2, 1'b0);
    press(4'h7);
    system_state = STATE_TRIGGER;
    tick(2);
    push("trigger_keeps_digit", K_CHG, -1, -1, 1'b0, 1'b0, 3'd2, 2'd2, 1'b0);
    press(4'h8);
    push("reset_mid_entry", K_CHG, -1, cyc + 1, 1'b0, 1'b0, 3'd0, 2'd3, 1'b0);
    rst = 1'b0;
    tick(1);
    rst = 1'b1;
    tick(5);
    system_state = STATE_IDLE;
    tick(2);
    push("reset_idle", K_SNAP, -1, cyc + 1, 1'b0, 1'b0, 3'd0, 2'd3, 1'b0);
    rst = 1'b0;
    tick(1);
    rst = 1'b1;
    tick(5);

    done = 1'b1;
    for (int i = 0; i < 20 && !final_done; i++) @(negedge clk);
    if (!final_done) begin
      $display("FAIL final_check: got no final scoreboard check, want one within 20 cycles");
      $fatal(1);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/passcode_entry.md
PASSCODE_ENTRY -- requirements
Module: passcode_entry

Interface
REQ-001 SHALL have parameter PASSCODE, default 16'h1234, meaning the 4-digit code, one 4-bit digit per nibble, first digit in bits [15:12].
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 1_000_000, meaning the number of cycles btn_enter must stay stable (20 ms at 50 MHz).
REQ-003 SHALL have parameter LOCKOUT_CYCLES, default 500_000_000, meaning the lockout duration (10 s at 50 MHz).
REQ-004 SHALL have parameter MAX_ATTEMPTS, default 3, meaning the number of wrong codes allowed before lockout.
REQ-005 SHALL have port clk, input, 1 bit: system clock.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous and active-low.
REQ-007 SHALL have port btn_enter, input, 1 bit: raw active-low push button that commits one digit.
REQ-008 SHALL have port digit_sw, input, 4 bits: digit value sampled on commit.
REQ-009 SHALL have port system_state, input, fsm_state_t: current alarm state, from the alarm controller.
REQ-010 SHALL have port passcode_correct, output, 1 bit: level; the code was matched. Feeds the alarm controller.
REQ-011 SHALL have port passcode_wrong, output, 1 bit: one-cycle pulse per mismatched code.
REQ-012 SHALL have port digits_entered, output, 3 bits: count of digits buffered, range 0..4, for the display.
REQ-013 SHALL have port attempts_left, output, 2 bits: remaining tries, range 0..MAX_ATTEMPTS.
REQ-014 SHALL have port locked_out, output, 1 bit: high during lockout.

Function
REQ-015 SHALL pass btn_enter through a 2-flop synchronizer and a debounce counter, then produce a press pulse: one cycle high on each debounced high-to-low transition.
REQ-016 SHALL implement the states P_DISARMED, P_ENTRY, P_CHECK, P_CORRECT and P_LOCKOUT.
REQ-017 P_DISARMED SHALL move to P_ENTRY on the next cycle once system_state is STATE_SET or STATE_TRIGGER.
REQ-018 In P_ENTRY, each press pulse SHALL shift digit_sw into the buffer, first digit at the MS nibble, and increment digits_entered.
REQ-019 When digits_entered reaches 4, the FSM SHALL go to P_CHECK on the next cycle.
REQ-020 P_CHECK SHALL last exactly 1 cycle and compare the buffer with PASSCODE over all 16 bits; digits 10–15 are stored and compared like any other value.
REQ-021 On a match, the FSM SHALL go to P_CORRECT; passcode_correct SHALL rise in the cycle after P_CHECK, which is 2 cycles after the 4th press pulse.
REQ-022 passcode_correct SHALL stay high until system_state becomes STATE_IDLE; then the FSM goes to P_DISARMED and passcode_correct drops on the next cycle.
REQ-023 On a mismatch: passcode_wrong SHALL pulse 1 cycle, attempts_left SHALL decrement, and the buffer and digits_entered SHALL clear to 0.
REQ-024 After a mismatch, the FSM SHALL go to P_LOCKOUT if attempts_left becomes 0, otherwise to P_ENTRY.
REQ-025 P_LOCKOUT SHALL count LOCKOUT_CYCLES cycles, then reload attempts_left to MAX_ATTEMPTS and go to P_ENTRY; locked_out SHALL be high throughout P_LOCKOUT.
REQ-026 The lockout counter SHALL be 32 bits and SHALL saturate, never wrap.
REQ-027 Press pulses in P_DISARMED, P_CHECK, P_CORRECT or P_LOCKOUT SHALL be dropped, not queued.
REQ-028 In any state, system_state equal to STATE_IDLE or STATE_ALERT SHALL force P_DISARMED next cycle and clear the buffer, digits_entered and passcode_correct.
REQ-029 The forced return of REQ-028 SHALL take priority over a same-cycle press, a P_CHECK result or lockout expiry.
REQ-030 attempts_left SHALL reload to MAX_ATTEMPTS only on STATE_IDLE, at reset, and at lockout expiry; STATE_ALERT SHALL preserve it.
REQ-031 A transition STATE_SET -> STATE_TRIGGER SHALL NOT clear a partially entered code.
REQ-032 All outputs SHALL be registered.

Reset
REQ-033 While rst is low at a clk edge, the block SHALL return to P_DISARMED.
REQ-034 Reset values SHALL be: passcode_correct=0, passcode_wrong=0, digits_entered=0, attempts_left=MAX_ATTEMPTS, locked_out=0, buffer=0, lockout counter=0, debounce state=released.
REQ-035 A reset mid-entry or mid-lockout SHALL abandon the operation with no pulse emitted.

Structure
REQ-036 fsm_state_t (STATE_IDLE, STATE_SET, STATE_TRIGGER, STATE_ALERT) and the constant CLK_HZ=50_000_000 SHALL live in the shared system package; the P_* state type stays local to this module.
REQ-037 The synchronizer, debounce and edge detector SHALL form one sub-module, button_debounce, with parameter DEBOUNCE_CYCLES, reusable for btn1.

Verification (DEBOUNCE_CYCLES=4, LOCKOUT_CYCLES=20, PASSCODE=16'h1234)
REQ-038 State STATE_SET; press digits 1,2,3,4 -> digits_entered steps 1..4, passcode_correct=1 exactly 2 cycles after the 4th press pulse, and it holds until system_state=STATE_IDLE.
REQ-039 State STATE_SET; enter 1,2,3,5 -> passcode_wrong pulses 1 cycle, attempts_left 3->2, digits_entered=0, passcode_correct stays 0.
REQ-040 Three wrong codes -> locked_out=1 for 20 cycles; presses during lockout have no effect; then attempts_left=3 and the correct code is accepted.
REQ-041 Button bouncing for 3 cycles, then held low for 10 cycles -> exactly one digit committed.
REQ-042 Two digits entered, then system_state=STATE_ALERT -> digits_entered=0 next cycle and attempts_left unchanged; with system_state=STATE_IDLE, rst low for 1 cycle -> all outputs take their reset values.
